// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester mux arbiter.
// Holds the arbiter state encoding, requester identity and mux select values.
// Imported by mux_arbiter; no logic of its own.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } requester_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage : mux_arb_pkg

// File: rtl/mux.sv
// Single-bit 2:1 multiplexer.
// Latency: combinational.
// Backpressure: none; ports i_a, i_b, i_sel (0 picks i_a), o_y.
module mux (
    input  logic i_a,
    input  logic i_b,
    input  logic i_sel,
    output logic o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule : mux

// File: rtl/mux_arbiter.sv
// Round-robin arbiter for two producers sharing one 2:1 mux path; registers selected data.
// Latency: request -> grant 1 cycle; granted data -> y/valid 1 further cycle.
// Backpressure: a grant lasts while its req is held; MUX_ARBITER_HOLD_LIMIT_EN adds hold-limit preemption.
//
// Ports: clk, rst (async active-low), req_a/req_b (level requests), a/b (data),
//        gnt_a/gnt_b (one-hot or idle), sel (0=a, 1=b), y (registered data), valid.
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W   = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              sel,
    output logic [DATA_W-1:0] y,
    output logic              valid
);

    if (MAX_HOLD < 2) begin : g_max_hold_bad
        $error("mux_arbiter: MAX_HOLD must be at least 2");
    end

    arb_state_t        r_state;
    arb_state_t        w_next;
    requester_t        r_last;
    logic              r_sel;
    logic [DATA_W-1:0] r_y;
    logic              r_valid;
    logic [DATA_W-1:0] w_mux_y;

`ifdef MUX_ARBITER_HOLD_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_HOLD);

    logic [CNT_W-1:0] r_hold_cnt;
    logic             w_hold_max;

    assign w_hold_max = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));

    // Cleared on any state change (covers every grant entry), saturates while the grant is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_cnt <= '0;
        end else if (w_next != r_state) begin
            r_hold_cnt <= '0;
        end else if (r_state != IDLE && !w_hold_max) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: handover goes straight to the other grant with no IDLE bubble.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_a && req_b) begin
                    w_next = (r_last == REQ_A) ? GNT_B : GNT_A;
                end else if (req_a) begin
                    w_next = GNT_A;
                end else if (req_b) begin
                    w_next = GNT_B;
                end
            end
            GNT_A: begin
                if (!req_a) begin
                    w_next = req_b ? GNT_B : IDLE;
                end
`ifdef MUX_ARBITER_HOLD_LIMIT_EN
                else if (w_hold_max && req_b) begin
                    w_next = GNT_B;
                end
`endif
            end
            GNT_B: begin
                if (!req_b) begin
                    w_next = req_a ? GNT_A : IDLE;
                end
`ifdef MUX_ARBITER_HOLD_LIMIT_EN
                else if (w_hold_max && req_a) begin
                    w_next = GNT_A;
                end
`endif
            end
            default: w_next = IDLE;
        endcase
    end

    // Output decode: grants come straight off the state register.
    always_comb begin
        gnt_a = (r_state == GNT_A);
        gnt_b = (r_state == GNT_B);
    end

    // Combinational select feeding the y register, one mux cell per bit.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mux
        mux u_mux (
            .i_a   (a[gi]),
            .i_b   (b[gi]),
            .i_sel (r_sel),
            .o_y   (w_mux_y[gi])
        );
    end

    // Datapath and round-robin memory. sel/last only change on entry to a grant
    // state, so they hold their value through IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sel   <= SEL_A;
            r_last  <= REQ_B;
            r_y     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_y     <= w_mux_y;
            r_valid <= gnt_a | gnt_b;
            if (w_next == GNT_A) begin
                r_sel  <= SEL_A;
                r_last <= REQ_A;
            end else if (w_next == GNT_B) begin
                r_sel  <= SEL_B;
                r_last <= REQ_B;
            end
        end
    end

    assign sel   = r_sel;
    assign y     = r_y;
    assign valid = r_valid;

endmodule : mux_arbiter
